mult32_seq: RTL



---
 rtl/mult32_seq_pkg.sv | 19 +
 rtl/mult32_seq_adder32.sv | 16 +
 rtl/mult32_seq.sv | 87 ++++++++
 3 files changed

// File: rtl/mult32_seq_pkg.sv
// Shared constants for the iterative shift-and-add multiplier: operand width,
// FSM state encoding and the start-to-done latency in clock cycles.
package mult32_seq_pkg;

    // Operand width; the product is twice this wide.
    localparam int WIDTH = 32;

    // Iteration counter width; 2**CNT_W must exceed WIDTH.
    localparam int CNT_W = 6;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Cycles from the accepting edge of start to the cycle in which done is high.
    localparam int MUL_LAT = 33;

endpackage

// File: rtl/mult32_seq_adder32.sv
// Unsigned W-bit adder with carry in and carry out. This is the single
// arithmetic element that the multiplier reuses on every iteration.
module adder32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         Cin,
    output logic [W-1:0] Sum,
    output logic         Cout
);

    // Full-width add; the carry out is the extra top bit of the result.
    assign {Cout, Sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, Cin};

endmodule

// File: rtl/mult32_seq.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH iterative multiplier. One add/shift step
// per clock for WIDTH cycles, then a single-cycle done pulse. The {hi, lo}
// register pair is the product output; it holds until the next accepted start.
module mult32_seq
    import mult32_seq_pkg::*;
#(
    parameter int WIDTH = mult32_seq_pkg::WIDTH,
    parameter int CNT_W = mult32_seq_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_c;

    // Partial-product selection: add the multiplicand only when the current
    // multiplier bit (the LSB of lo, which shifts right each step) is set.
    assign w_addend = r_lo[0] ? r_mcand : '0;

    adder32 #(
        .W    (WIDTH)
    ) u_adder (
        .a    (r_hi),
        .b    (w_addend),
        .Cin  (1'b0),
        .Sum  (w_sum),
        .Cout (w_c)
    );

    // FSM, iteration counter and datapath registers. In RUN the 65-bit value
    // {c, sum, lo} is shifted right by one, so the adder carry lands in the
    // MSB of hi instead of being lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_hi    <= '0;
                        r_lo    <= b;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_hi  <= {w_c, w_sum[WIDTH-1:1]};
                    r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign product = {r_hi, r_lo};
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);

endmodule
